// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if
//   Bundles the FIFO read port and the packed output stream of the word
//   packer.
//   FIFO side   : fifo_empty, fifo_rd_en, fifo_rdata (WIDTH bits)
//   Stream side : out_data (WIDTH*BEATS), out_keep (BEATS), out_valid,
//                 out_ready
//   Modports    : master - the packer (drives fifo_rd_en and the stream)
//                 slave  - the FIFO / downstream environment
interface fifo_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int BEATS = 4
);
    logic                     fifo_empty;
    logic                     fifo_rd_en;
    logic [WIDTH-1:0]         fifo_rdata;
    logic [WIDTH*BEATS-1:0]   out_data;
    logic [BEATS-1:0]         out_keep;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  fifo_empty,
        output fifo_rd_en,
        input  fifo_rdata,
        output out_data,
        output out_keep,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output fifo_empty,
        input  fifo_rd_en,
        output fifo_rdata,
        input  out_data,
        input  out_keep,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Read-side consumer for the async FIFO (read clock domain). Drains
//   WIDTH-bit entries without ever reading an empty FIFO and packs BEATS
//   consecutive entries into one wide word on a valid/ready stream. The
//   first entry lands in out_data[WIDTH-1:0].
//   Ports:
//     clk        FIFO read clock
//     res        synchronous reset, active-high
//     bus        fifo_word_packer_if.master (FIFO read port + output stream)
//     words_out  16-bit count of accepted words, wraps
//   Optional feature (macro PACKER_FLUSH_EN): after FLUSH_CYCLES idle cycles
//   with a partially filled word, emit it with out_keep marking the filled
//   lanes. Without the macro a partial word waits for more entries.
module fifo_word_packer #(
    parameter int WIDTH        = 8,
    parameter int BEATS        = 4,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic                clk,
    input  logic                res,
    fifo_word_packer_if.master  bus,
    output logic [15:0]         words_out
);
    if (BEATS < 2 || BEATS > 16 || FLUSH_CYCLES < 1) begin : g_bad_cfg
        $error("fifo_word_packer: BEATS must be 2..16 and FLUSH_CYCLES >= 1");
    end

    localparam int FW = $clog2(BEATS + 1);
    localparam int IW = $clog2(BEATS);
    localparam logic [FW-1:0] FULL = FW'(BEATS);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
`ifdef PACKER_FLUSH_EN
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_MAX = CW'(FLUSH_CYCLES);
`endif

    logic [1:0]                  state;
    logic [FW-1:0]               fill;
    logic                        inflight;
    logic [BEATS-1:0][WIDTH-1:0] asm_q;
    logic [FW:0]                 pending;
    logic                        accept;
    logic                        slot_free;
    logic                        emit;

    // Entries already captured plus the one still in flight; a read is only
    // issued while the word has room for it.
    assign pending   = {1'b0, fill} + {{FW{1'b0}}, inflight};
    assign bus.fifo_rd_en = !res && !bus.fifo_empty &&
                            (pending < {1'b0, FULL}) && (state == ST_FILL);
    assign accept    = bus.out_valid && bus.out_ready;
    assign slot_free = !bus.out_valid || bus.out_ready;

`ifdef PACKER_FLUSH_EN
    logic [CW-1:0]    flush_cnt;
    logic [BEATS-1:0] partial_keep;

    assign emit = slot_free && (state == ST_HOLD || state == ST_FLUSH);

    always_comb begin
        partial_keep = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (FW'(i) < fill) partial_keep[IW'(i)] = 1'b1;
        end
    end
`else
    assign emit = slot_free && (state == ST_HOLD);
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state         <= ST_FILL;
            fill          <= '0;
            inflight      <= 1'b0;
            asm_q         <= '0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
            bus.out_valid <= 1'b0;
            words_out     <= '0;
`ifdef PACKER_FLUSH_EN
            flush_cnt     <= '0;
`endif
        end else begin
            inflight <= bus.fifo_rd_en;

            if (accept) begin
                words_out     <= words_out + 16'd1;
                bus.out_valid <= 1'b0;
            end

            if (state == ST_FILL) begin
                if (inflight) begin
                    asm_q[fill[IW-1:0]] <= bus.fifo_rdata;
                    fill                <= fill + FW'(1);
                    // Go straight to HOLD on the final capture so the word
                    // can transfer on the very next edge.
                    if ((fill + FW'(1)) == FULL) state <= ST_HOLD;
                end
`ifdef PACKER_FLUSH_EN
                // A read issued this cycle would be lost in FLUSH.
                else if (flush_cnt == FLUSH_MAX && !bus.fifo_rd_en) begin
                    state <= ST_FLUSH;
                end
`endif
            end else if (emit) begin
                bus.out_data  <= asm_q;
`ifdef PACKER_FLUSH_EN
                bus.out_keep  <= (state == ST_HOLD) ? '1 : partial_keep;
`else
                bus.out_keep  <= '1;
`endif
                bus.out_valid <= 1'b1;
                fill          <= '0;
                asm_q         <= '0;
                state         <= ST_FILL;
            end

`ifdef PACKER_FLUSH_EN
            if (inflight || emit) begin
                flush_cnt <= '0;
            end else if (state == ST_FILL && fill != '0 && bus.fifo_empty &&
                         flush_cnt != FLUSH_MAX) begin
                flush_cnt <= flush_cnt + CW'(1);
            end
`endif
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Scoreboard bench for fifo_word_packer (WIDTH=8, BEATS=4,
//   FLUSH_CYCLES=64). A behavioural FIFO feeds the packer; expected words are
//   queued by the stimulus and popped by a forked monitor on every accepted
//   output word.
module tb_fifo_word_packer;
    logic        clk = 1'b0;
    logic        res;
    logic [15:0] words_out;

    always #5 clk = ~clk;

    fifo_word_packer_if #(.WIDTH(8), .BEATS(4)) bus ();

    fifo_word_packer #(
        .WIDTH(8),
        .BEATS(4),
        .FLUSH_CYCLES(64)
    ) dut (
        .clk       (clk),
        .res       (res),
        .bus       (bus),
        .words_out (words_out)
    );

    // Behavioural FIFO: data appears one clk after a read strobe.
    logic [7:0] mem [0:255];
    int         wr_ptr      = 0;
    int         rd_ptr      = 0;
    logic       force_empty = 1'b0;
    int         rd_count    = 0;
    int         underflow   = 0;

    assign bus.fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_count <= rd_count + 1;
            if (bus.fifo_empty) begin
                underflow <= underflow + 1;
            end else begin
                bus.fifo_rdata <= mem[rd_ptr[7:0]];
                rd_ptr         <= rd_ptr + 1;
            end
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;
    int   viol   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.data = d;
        e.keep = k;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        exp_q.delete();
        force_empty = 1'b0;
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!res) begin
                if (bus.out_valid) vcount++;
                if (bus.fifo_rd_en && bus.fifo_empty) viol++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%h required=none", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", bus.out_data, e.data);
                        chk("word_keep", {28'h0, bus.out_keep}, {28'h0, e.keep});
                    end
                end
            end
        end
    endtask

    initial begin
        int   base_v;
        int   base_rd;
        logic rd_seen;

        fork
            monitor();
        join_none

        // Reset with a non-empty FIFO: no reads, outputs cleared.
        res           = 1'b1;
        bus.out_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rd_seen = bus.fifo_rd_en;
        for (int i = 0; i < 3; i++) begin
            tick();
            rd_seen = rd_seen | bus.fifo_rd_en;
        end
        chk("rd_en_in_reset", {31'h0, rd_seen}, 0);
        chk("reset_out_valid", {31'h0, bus.out_valid}, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_keep", {28'h0, bus.out_keep}, 0);
        chk("reset_words_out", {16'h0, words_out}, 0);

        // Single word streaming through.
        base_v = vcount;
        bus.out_ready = 1'b1;
        expect_word(32'h44332211, 4'hF);
        res = 1'b0;
        wait_drain(50, "stream_drain");
        repeat (3) tick();
        chk("stream_valid_cycles", vcount - base_v, 1);
        chk("stream_words_out", {16'h0, words_out}, 1);
        chk("stream_underflow", underflow, 0);

        // Backpressure: 12 entries, downstream stalled for 20 clks.
        apply_reset();
        bus.out_ready = 1'b0;
        base_rd = rd_count;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        push(8'h99); push(8'hAA); push(8'hBB); push(8'hCC);
        expect_word(32'h44332211, 4'hF);
        expect_word(32'h88776655, 4'hF);
        expect_word(32'hCCBBAA99, 4'hF);
        repeat (20) tick();
        chk("bp_hold_valid", {31'h0, bus.out_valid}, 1);
        chk("bp_hold_data", bus.out_data, 32'h44332211);
        chk("bp_reads", rd_count - base_rd, 8);
        chk("bp_rd_en_idle", {31'h0, bus.fifo_rd_en}, 0);
        bus.out_ready = 1'b1;
        wait_drain(60, "bp_drain");
        repeat (2) tick();
        chk("bp_words_out", {16'h0, words_out}, 3);

        // Empty flag toggling every clk.
        apply_reset();
        force_empty = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        push(8'hA5); push(8'hA6); push(8'hA7); push(8'hA8);
        expect_word(32'hA4A3A2A1, 4'hF);
        expect_word(32'hA8A7A6A5, 4'hF);
        repeat (60) begin
            tick();
            force_empty = !force_empty;
        end
        force_empty = 1'b0;
        wait_drain(40, "gaps_drain");
        repeat (2) tick();
        chk("gaps_rd_while_empty", viol, 0);
        chk("gaps_underflow", underflow, 0);
        chk("gaps_words_out", {16'h0, words_out}, 2);

        // Partial word then idle FIFO.
        apply_reset();
        push(8'hAA); push(8'hBB);
`ifdef PACKER_FLUSH_EN
        expect_word(32'h0000BBAA, 4'b0011);
        wait_drain(200, "flush_drain");
        repeat (2) tick();
        chk("flush_words_out", {16'h0, words_out}, 1);
`else
        base_v = vcount;
        repeat (200) tick();
        chk("noflush_valid_cycles", vcount - base_v, 0);
        chk("noflush_words_out", {16'h0, words_out}, 0);
`endif

        // Reset in the middle of a word.
        apply_reset();
        push(8'hE1); push(8'hE2); push(8'hE3);
        repeat (6) tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        expect_word(32'h04030201, 4'hF);
        wait_drain(50, "midreset_drain");
        repeat (2) tick();
        chk("midreset_words_out", {16'h0, words_out}, 1);
        chk("final_underflow", underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
